// File: rtl/rs_pulse_gen.sv
// Debounced two-button front end that drives the R/S inputs of an RS flip-flop
// with fixed-width, mutually exclusive pulses separated by a one-cycle gap.
module rs_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  logic [1:0] w_btn;
  logic [1:0] w_req;
  logic       w_req_s, w_req_r, w_diff_req, w_go, w_go_set;

  state_t          r_state;
  logic            r_s, r_r, r_busy;
  logic            r_pend_valid, r_pend_set, r_last_set;
  logic [PW-1:0]   r_pcnt;

  // Channel 0 is the set button, channel 1 the reset button.
  assign w_btn = {reset_btn, set_btn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic          r_sync1, r_sync2, r_stable, r_stable_d;
      logic [DW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_sync1    <= w_btn[gi];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end
      end

      assign w_req[gi] = r_stable & ~r_stable_d;
    end
  endgenerate

  assign w_req_s    = w_req[0];
  assign w_req_r    = w_req[1];
  // A request is only worth queueing if it is the opposite type of the last pulse.
  assign w_diff_req = r_last_set ? w_req_r : w_req_s;

  always_comb begin
    w_go     = 1'b0;
    w_go_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_go     = w_req_s | w_req_r;
        w_go_set = ~w_req_r;
      end
      ST_GAP: begin
        w_go     = r_pend_valid | w_diff_req;
        w_go_set = r_pend_valid ? r_pend_set : ~r_last_set;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_s          <= 1'b0;
      r_r          <= 1'b0;
      r_busy       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_set   <= 1'b0;
      r_last_set   <= 1'b0;
      r_pcnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_go) begin
            r_state    <= w_go_set ? ST_PULSE_S : ST_PULSE_R;
            r_s        <= w_go_set;
            r_r        <= ~w_go_set;
            r_busy     <= 1'b1;
            r_last_set <= w_go_set;
            r_pcnt     <= '0;
          end else begin
            r_state <= ST_IDLE;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_busy  <= 1'b0;
          end
          // Simultaneous presses: reset goes first, set waits in the slot.
          if (r_state == ST_IDLE) begin
            if (w_req_s && w_req_r) begin
              r_pend_valid <= 1'b1;
              r_pend_set   <= 1'b1;
            end
          end else begin
            r_pend_valid <= 1'b0;
          end
        end
        default: begin
          if (!r_pend_valid && w_diff_req) begin
            r_pend_valid <= 1'b1;
            r_pend_set   <= ~r_last_set;
          end
          if (r_pcnt == P_LAST) begin
            r_state <= ST_GAP;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt + PW'(1);
          end
        end
      endcase
    end
  end

  assign S    = r_s;
  assign R    = r_r;
  assign busy = r_busy;

endmodule

// File: tb/tb_rs_pulse_gen.sv
// Directed bench for rs_pulse_gen (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3) with a
// per-cycle monitor for R/S exclusivity and pulse width.
module tb_rs_pulse_gen;
  localparam int PC = 3;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic set_btn   = 1'b0;
  logic reset_btn = 1'b0;
  logic S, R, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int s_run    = 0;
  int r_run    = 0;

  always #5 clk = ~clk;

  rs_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (PC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_btn  (set_btn),
    .reset_btn(reset_btn),
    .S        (S),
    .R        (R),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int k, input logic es, input logic er, input logic eb);
    chk($sformatf("%s e%0d S", tag, k), S, es);
    chk($sformatf("%s e%0d R", tag, k), R, er);
    chk($sformatf("%s e%0d busy", tag, k), busy, eb);
  endtask

  task automatic idle_wait(input int n);
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    repeat (n) step();
  endtask

  // Exclusivity every cycle; width checked when a pulse ends without reset.
  always @(negedge clk) begin
    n_checks++;
    assert (!(S && R)) else begin
      n_fail++;
      $error("FAIL overlap: S=%b R=%b, required not both 1", S, R);
    end
    if (S) s_run++;
    else begin
      if (s_run != 0 && !rst) begin
        n_checks++;
        assert (s_run == PC) else begin
          n_fail++;
          $error("FAIL s_width: observed %0d expected %0d", s_run, PC);
        end
      end
      s_run = 0;
    end
    if (R) r_run++;
    else begin
      if (r_run != 0 && !rst) begin
        n_checks++;
        assert (r_run == PC) else begin
          n_fail++;
          $error("FAIL r_width: observed %0d expected %0d", r_run, PC);
        end
      end
      r_run = 0;
    end
  end

  initial begin
    step();
    step();
    chk3("reset", 0, 1'b0, 1'b0, 1'b0);

    // Clean set press.
    rst     = 1'b0;
    set_btn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk3("clean", k, (k >= 7 && k <= 9), 1'b0, (k >= 7 && k <= 10));
    end
    idle_wait(12);

    // Bouncing set line, then settles high.
    for (int c = 0; c < 20; c++) begin
      set_btn = ((c % 4) < 2);
      step();
      chk($sformatf("bounce c%0d S", c), S, 1'b0);
    end
    set_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk3("settle", k, (k >= 7 && k <= 9), 1'b0, (k >= 7 && k <= 10));
    end
    idle_wait(12);

    // Both buttons together: reset first, then set after one gap cycle.
    set_btn   = 1'b1;
    reset_btn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk3("both", k, (k >= 11 && k <= 13), (k >= 7 && k <= 9), (k >= 7 && k <= 14));
    end
    idle_wait(12);

    // Reset request during an S pulse; short set re-press is ignored.
    set_btn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) reset_btn = 1'b1;
      if (k == 8) set_btn = 1'b0;
      if (k == 9) set_btn = 1'b1;
      step();
      chk3("chain", k, (k >= 7 && k <= 9), (k >= 11 && k <= 13), (k >= 7 && k <= 14));
    end
    idle_wait(12);

    // rst in the second cycle of an R pulse drops the pending set.
    set_btn   = 1'b1;
    reset_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk3("prerst", k, 1'b0, (k >= 7), (k >= 7));
    end
    rst       = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    step();
    chk3("midrst", 9, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk3("postrst", k, 1'b0, 1'b0, 1'b0);
    end

    // Button held through reset is a fresh press after release.
    set_btn = 1'b1;
    rst     = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk3("held", k, (k >= 7 && k <= 9), 1'b0, (k >= 7 && k <= 10));
    end
    idle_wait(12);

    // Random traffic; the monitor does the checking.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) set_btn = ~set_btn;
      if ($urandom_range(7) == 0) reset_btn = ~reset_btn;
      step();
    end
    idle_wait(30);
    chk("random settle busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
